// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the scanned seven-segment decoder: segment patterns,
// FSM state encoding and the active-low bit conventions of the display bus.
package seg_scan_decoder_pkg;

    localparam int SEG_W   = 8;
    localparam int DP_BIT  = 7;
    localparam int SEG_MSB = 6;

    // Both the segment lines and the digit enables are driven low when active.
    localparam logic SEG_ACTIVE = 1'b0;
    localparam logic AN_ACTIVE  = 1'b0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_HOLD   = 2'd2;

    // Index k holds the g..a pattern that displays hex digit k.
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_scan_decoder_lut.sv
// Reverse lookup from a seven-segment pattern to its hex nibble; purely
// combinational, with match low when the pattern is not one of the 16 codes.
module seg_pattern_lut
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       match
);

    logic [15:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_cmp
            assign hit[gi] = (seg == SEG_PATTERNS[gi]);
        end
    endgenerate

    // Patterns are distinct, so at most one hit bit is ever set.
    always_comb begin
        nibble = 4'd0;
        match  = |hit;
        for (int k = 0; k < 16; k++) begin
            if (hit[k]) begin
                nibble = 4'(k);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers digit values from a multiplexed seven-segment display: waits for
// each dwell to settle, captures the digit once and assembles whole frames.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg,
    input  logic [N_DIGITS-1:0]   an,
    output logic [4*N_DIGITS-1:0] out_data,
    output logic [N_DIGITS-1:0]   out_dp,
    output logic [N_DIGITS-1:0]   out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int SAMP_W = SEG_W + N_DIGITS;
    localparam logic [N_DIGITS-1:0] ONE = N_DIGITS'(1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SAMP_W-1:0]     samp_q, samp_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic [4*N_DIGITS-1:0] dig_data_q, dig_data_d;
    logic [N_DIGITS-1:0]   dig_dp_q, dig_dp_d;
    logic [N_DIGITS-1:0]   dig_err_q, dig_err_d;
    logic [4*N_DIGITS-1:0] out_data_q, out_data_d;
    logic [N_DIGITS-1:0]   out_dp_q, out_dp_d;
    logic [N_DIGITS-1:0]   out_err_q, out_err_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overrun_q, overrun_d;

    logic [N_DIGITS-1:0]   sel_hot;
    logic                  sel_valid;
    logic [SAMP_W-1:0]     sample;
    logic                  same;
    logic                  capture;
    logic [N_DIGITS-1:0]   cap_hot;
    logic [N_DIGITS-1:0]   seen_set;
    logic                  frame_done;
    logic [3:0]            lut_nibble;
    logic                  lut_match;

    seg_pattern_lut u_lut (
        .seg    (seg[SEG_MSB:0]),
        .nibble (lut_nibble),
        .match  (lut_match)
    );

    // A digit is selected only when exactly its enable is asserted.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_sel
            assign sel_hot[gi] = ((an ^ {N_DIGITS{~AN_ACTIVE}}) == (ONE << gi));
        end
    endgenerate

    assign sel_valid = |sel_hot;
    assign sample    = {seg, an};
    assign same      = (sample == samp_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        samp_d  = samp_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(1);
                    samp_d  = sample;
                end
            end
            ST_SETTLE: begin
                if (!sel_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    cnt_d  = CNT_W'(1);
                    samp_d = sample;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(STABLE_CYCLES);
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!sel_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(1);
                    samp_d  = sample;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign cap_hot    = capture ? sel_hot : '0;
    assign seen_set   = seen_q | cap_hot;
    assign frame_done = capture && (&seen_set);

    always_comb begin
        dig_data_d = dig_data_q;
        dig_dp_d   = dig_dp_q;
        dig_err_d  = dig_err_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (cap_hot[i]) begin
                dig_data_d[4*i +: 4] = lut_nibble;
                dig_dp_d[i]          = (seg[DP_BIT] == SEG_ACTIVE);
                dig_err_d[i]         = ~lut_match;
            end
        end
    end

    // The completing digit is taken from the _d values so it lands in the frame.
    always_comb begin
        seen_d      = frame_done ? '0 : seen_set;
        out_data_d  = out_data_q;
        out_dp_d    = out_dp_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        if (frame_done) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = dig_data_d;
                out_dp_d    = dig_dp_d;
                out_err_d   = dig_err_d;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            samp_q      <= '0;
            seen_q      <= '0;
            dig_data_q  <= '0;
            dig_dp_q    <= '0;
            dig_err_q   <= '0;
            out_data_q  <= '0;
            out_dp_q    <= '0;
            out_err_q   <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            samp_q      <= samp_d;
            seen_q      <= seen_d;
            dig_data_q  <= dig_data_d;
            dig_dp_q    <= dig_dp_d;
            dig_err_q   <= dig_err_d;
            out_data_q  <= out_data_d;
            out_dp_q    <= out_dp_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_dp    = out_dp_q;
    assign out_err   = out_err_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans hand-built digit sequences and
// compares the assembled frames against hand-computed values.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] out_data;
    logic [3:0]  out_dp;
    logic [3:0]  out_err;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;

    int          checks = 0;
    int          errors = 0;
    int          rises  = 0;
    int          base;
    logic        valid_prev = 1'b0;
    logic [15:0] frame_data;
    logic [3:0]  frame_dp;
    logic [3:0]  frame_err;

    seg_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg       (seg),
        .an        (an),
        .out_data  (out_data),
        .out_dp    (out_dp),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Frame monitor: one line per delivered frame, latched on out_valid rising.
    always @(negedge clk) begin
        if (out_valid && !valid_prev) begin
            rises      = rises + 1;
            frame_data = out_data;
            frame_dp   = out_dp;
            frame_err  = out_err;
            $display("frame %0d data=%h dp=%b err=%b t=%0t", rises, out_data, out_dp, out_err, $time);
        end
        valid_prev = out_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic show(input int idx, input logic [7:0] pat, input int dwell);
        seg = pat;
        an  = ~(4'b0001 << idx);
        repeat (dwell) @(negedge clk);
    endtask

    task automatic blank(input int cycles);
        seg = 8'hFF;
        an  = 4'hF;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        seg = 8'hFF;
        an  = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        seg       = 8'hFF;
        an        = 4'hF;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid",   32'(out_valid), 32'h0);
        check("rst_data",    32'(out_data),  32'h0);
        check("rst_dp",      32'(out_dp),    32'h0);
        check("rst_err",     32'(out_err),   32'h0);
        check("rst_overrun", 32'(overrun),   32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic scan 1,2,3,4 with DP segment driven low (lit) on every digit.
        base = rises;
        show(0, 8'h79, 8); show(1, 8'h24, 8); show(2, 8'h30, 8); show(3, 8'h19, 8);
        blank(4);
        check("scan_frames", 32'(rises - base), 32'd1);
        check("scan_data",   32'(frame_data),   32'h4321);
        check("scan_err",    32'(frame_err),    32'h0);
        check("scan_dp",     32'(frame_dp),     32'hF);
        check("scan_vfall",  32'(out_valid),    32'h0);

        // Digit 0 never settles, so the remaining three cannot complete a frame.
        do_reset();
        base = rises;
        for (int t = 0; t < 5; t++) begin
            show(0, 8'hC0, 2);
            show(0, 8'hF9, 2);
        end
        show(1, 8'hF9, 8); show(2, 8'hA4, 8); show(3, 8'hB0, 8);
        blank(4);
        check("toggle_frames", 32'(rises - base), 32'd0);
        check("toggle_valid",  32'(out_valid),    32'h0);

        // Illegal pattern 7F on digit 2.
        do_reset();
        base = rises;
        show(0, 8'hC0, 8); show(1, 8'hF9, 8); show(2, 8'hFF, 8); show(3, 8'hB0, 8);
        blank(4);
        check("illegal_frames", 32'(rises - base), 32'd1);
        check("illegal_data",   32'(frame_data),   32'h3010);
        check("illegal_err",    32'(frame_err),    32'h4);
        check("illegal_dp",     32'(frame_dp),     32'h0);

        // DP lit only on digit 1; err bit 2 clears on a legal recapture.
        base = rises;
        show(0, 8'hC0, 8); show(1, 8'h79, 8); show(2, 8'hA4, 8); show(3, 8'hB0, 8);
        blank(4);
        check("dp_frames", 32'(rises - base), 32'd1);
        check("dp_data",   32'(frame_data),   32'h3210);
        check("dp_bits",   32'(frame_dp),     32'h2);
        check("dp_err",    32'(frame_err),    32'h0);

        // Dwell of STABLE_CYCLES-1 is too short; exactly STABLE_CYCLES captures.
        base = rises;
        show(0, 8'h80, 8); show(1, 8'h98, 8); show(2, 8'h88, 8); show(3, 8'h83, 3);
        blank(4);
        check("short_frames", 32'(rises - base), 32'd0);
        show(3, 8'h83, 4);
        blank(4);
        check("exact_frames", 32'(rises - base), 32'd1);
        check("exact_data",   32'(frame_data),   32'hBA98);

        // Consumer stalled across two frames: first is kept, second dropped.
        do_reset();
        base = rises;
        out_ready = 1'b0;
        show(0, 8'hF9, 8); show(1, 8'hA4, 8); show(2, 8'hB0, 8); show(3, 8'h99, 8);
        show(0, 8'hC0, 8); show(1, 8'hC0, 8); show(2, 8'hC0, 8); show(3, 8'hC0, 8);
        blank(4);
        check("ovr_frames",  32'(rises - base), 32'd1);
        check("ovr_valid",   32'(out_valid),    32'h1);
        check("ovr_data",    32'(out_data),     32'h4321);
        check("ovr_flag",    32'(overrun),      32'h1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_vfall",   32'(out_valid),    32'h0);
        check("ovr_sticky",  32'(overrun),      32'h1);
        @(negedge clk);

        // Reset in the middle of a frame and of a dwell discards partial captures.
        do_reset();
        show(0, 8'h80, 8); show(1, 8'h98, 8); show(2, 8'h88, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_data",    32'(out_data), 32'h0);
        check("mid_rst_overrun", 32'(overrun),  32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        blank(1);
        base = rises;
        show(2, 8'hC6, 8); show(3, 8'hA1, 8);
        blank(4);
        check("post_rst_partial", 32'(rises - base), 32'd0);
        show(0, 8'h88, 8); show(1, 8'h83, 8);
        blank(4);
        check("post_rst_frames", 32'(rises - base), 32'd1);
        check("post_rst_data",   32'(frame_data),   32'hDCBA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digit positions.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, consecutive identical samples (at least 2) required to accept a digit.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port seg, input, 8, active-low segment bus: bit7 DP, bits6:0 segments g..a.
REQ-006 SHALL have port an, input, N_DIGITS, active-low digit enables from the scanned display.
REQ-007 SHALL have port out_data, output, 4*N_DIGITS, decoded nibbles; digit i occupies bits 4i+3:4i.
REQ-008 SHALL have port out_dp, output, N_DIGITS, per-digit DP, 1 = lit.
REQ-009 SHALL have port out_err, output, N_DIGITS, per-digit flag: 1 = pattern in the frame was not one of the 16 legal codes.
REQ-010 SHALL have port out_valid, output, 1, frame available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the frame.
REQ-012 SHALL have port overrun, output, 1, sticky flag: a frame was dropped.

Function
REQ-013 SHALL treat an as selecting digit i only when exactly bit i is 0; any other value is "no selection".
REQ-014 SHALL run FSM IDLE/SETTLE/HOLD. IDLE->SETTLE on a selection. SETTLE->HOLD when {seg,an} is unchanged for STABLE_CYCLES consecutive samples. SETTLE restarts count at 1 on any change. HOLD->SETTLE on {seg,an} change to another selection. SETTLE/HOLD->IDLE on no selection.
REQ-015 SHALL capture the digit exactly once per dwell, on the SETTLE->HOLD edge; latency from first stable sample to capture is STABLE_CYCLES cycles.
REQ-016 SHALL decode seg[6:0] by exact match: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=18,A=08,B=03,C=46,D=21,E=06,F=0E (hex).
REQ-017 SHALL, on no match, store nibble 0 and set that digit's err bit; on a match, clear that digit's err bit.
REQ-018 SHALL store DP as ~seg[7] at capture.
REQ-019 SHALL keep a per-digit "seen" bit, set at capture; when all bits are set, a frame is complete and all seen bits clear in the same cycle.
REQ-020 SHALL re-capture a digit already seen in the current frame, overwriting its stored value, without affecting other seen bits.
REQ-021 SHALL, on frame completion while out_valid=0, load out_data/out_dp/out_err and set out_valid the next cycle; the completing digit's new value is included.
REQ-022 SHALL hold out_valid and outputs stable until a cycle with out_valid=1 and out_ready=1; out_valid falls the next cycle.
REQ-023 SHALL accept a completing frame when out_valid=1 and out_ready=1 in the same cycle; out_valid remains 1 with new contents.
REQ-024 SHALL, on completion while out_valid=1 and out_ready=0, drop the new frame, keep outputs unchanged, and set overrun until reset.

Reset
REQ-025 SHALL on rst: FSM IDLE, stability count 0, seen bits 0, out_data 0, out_dp 0, out_err 0, out_valid 0, overrun 0.
REQ-026 SHALL, on reset mid-dwell or mid-frame, discard partial captures; the first capture after release requires a full STABLE_CYCLES settle.

Structure
REQ-027 SHALL place the 16 segment-pattern constants, FSM state encoding and the DP/active-low bit positions in a shared package.
REQ-028 SHALL implement the reverse lookup as combinational sub-module seg_pattern_lut (in seg[6:0]; out nibble, match).

Verification
REQ-029 Scan digits 0..3 with patterns 79,24,30,19, dwell 8 cycles each, out_ready=1 -> out_valid pulses once, out_data=16'h4321, out_err=0.
REQ-030 Digit 0 toggles between 40 and 79 every 2 cycles, STABLE_CYCLES=4 -> no capture for digit 0 and no frame.
REQ-031 Digit 2 shows 7F, others legal -> frame has nibble 2 = 0 and out_err=4'b0100.
REQ-032 Digit 1 seg=0x79 (DP lit) -> out_dp bit1=1; seg=0xF9 -> 0.
REQ-033 out_ready=0, two full frames -> first frame retained, overrun=1; raise out_ready -> out_valid falls the next cycle.
REQ-034 Assert rst after 2 digits captured, release, scan 4 digits -> exactly one frame, containing only post-reset values.
